// File: rtl/strram_pkg.sv
// Shared definitions for the string-RAM streaming controller: widths, default
// terminator, stream FSM encoding and arbiter index/priority names.
package strram_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 8;

   localparam logic [DATA_W-1:0] TERM_DEFAULT = 8'h00;
   localparam logic [ADDR_W-1:0] ADDR_LAST    = 8'hFF;

   // Request/grant bit positions shared by the top and the arbiter.
   localparam int REQ_CPU = 0;
   localparam int REQ_STR = 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      S_RD   = 3'd1,
      S_WAIT = 3'd2,
      S_SEND = 3'd3,
      S_DONE = 3'd4
   } stream_state_t;

   typedef enum logic {
      PRIO_CPU    = 1'b0,
      PRIO_STREAM = 1'b1
   } prio_t;

endpackage

// File: rtl/strram_rr_arb.sv
// Two-way round-robin arbiter: a lone request is granted at once; on a
// conflict the side that lost the previous conflict wins.
module strram_rr_arb
   import strram_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   prio_t prio_reg;
   prio_t prio_next;

   // Priority only moves on an actual conflict, so an uncontended stream of
   // requests from one side never starves the other of its next win.
   always_comb begin
      gnt       = 2'b00;
      prio_next = prio_reg;
      if (req == 2'b11) begin
         if (prio_reg == PRIO_CPU) begin
            gnt[REQ_CPU] = 1'b1;
            prio_next    = PRIO_STREAM;
         end else begin
            gnt[REQ_STR] = 1'b1;
            prio_next    = PRIO_CPU;
         end
      end else begin
         gnt = req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_reg <= PRIO_CPU;
      end else begin
         prio_reg <= prio_next;
      end
   end

endmodule

// File: rtl/strram_stream_ctrl.sv
// Shares one RAM port between a CPU and a string streamer that emits bytes
// until TERM_BYTE or address 8'hFF. Optional abort input: STRRAM_STREAM_ABORT_EN.
module strram_stream_ctrl
   import strram_pkg::*;
#(
   parameter logic [DATA_W-1:0] TERM_BYTE = TERM_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cpu_req,
   input  logic              cpu_wr,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              start,
   input  logic [ADDR_W-1:0] start_addr,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
`ifdef STRRAM_STREAM_ABORT_EN
   input  logic              abort,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_dat_in,
   input  logic [DATA_W-1:0] mem_dat_out,
   output logic              mem_rd,
   output logic              mem_wr
);

   stream_state_t     state_reg, state_next;
   logic [ADDR_W-1:0] ptr_reg, ptr_next;
   logic [DATA_W-1:0] tx_data_reg, tx_data_next;
   logic              cpu_ack_reg;
   logic              cpu_rd_pend_reg;
   logic [DATA_W-1:0] cpu_rdata_hold_reg;
   logic              abort_hit;
   logic              cpu_issue_req;
   logic              str_issue_req;
   logic [1:0]        gnt;

`ifdef STRRAM_STREAM_ABORT_EN
   assign abort_hit = abort;
`else
   assign abort_hit = 1'b0;
`endif

   // The CPU is done with its request in the ack cycle, so it never re-requests
   // back-to-back; that gap is what bounds stream contention to one cycle.
   assign cpu_issue_req = cpu_req & ~cpu_ack_reg & ~rst;
   assign str_issue_req = (state_reg == S_RD) & ~abort_hit & ~rst;

   strram_rr_arb u_arb (
      .clk (clk),
      .rst (rst),
      .req ({str_issue_req, cpu_issue_req}),
      .gnt (gnt)
   );

   always_comb begin
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      mem_addr   = '0;
      mem_dat_in = '0;
      if (gnt[REQ_CPU]) begin
         mem_addr = cpu_addr;
         if (cpu_wr) begin
            mem_wr     = 1'b1;
            mem_dat_in = cpu_wdata;
         end else begin
            mem_rd = 1'b1;
         end
      end else if (gnt[REQ_STR]) begin
         mem_rd   = 1'b1;
         mem_addr = ptr_reg;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cpu_ack_reg        <= 1'b0;
         cpu_rd_pend_reg    <= 1'b0;
         cpu_rdata_hold_reg <= '0;
      end else begin
         cpu_ack_reg     <= gnt[REQ_CPU];
         cpu_rd_pend_reg <= gnt[REQ_CPU] & ~cpu_wr;
         if (cpu_rd_pend_reg) begin
            cpu_rdata_hold_reg <= mem_dat_out;
         end
      end
   end

   // Read data is presented straight from the RAM in the ack cycle, then held.
   assign cpu_ack   = cpu_ack_reg;
   assign cpu_rdata = cpu_rd_pend_reg ? mem_dat_out : cpu_rdata_hold_reg;

   always_comb begin
      state_next   = state_reg;
      ptr_next     = ptr_reg;
      tx_data_next = tx_data_reg;
      case (state_reg)
         IDLE: begin
            if (start) begin
               ptr_next   = start_addr;
               state_next = S_RD;
            end
         end
         S_RD: begin
            if (abort_hit) begin
               state_next = S_DONE;
            end else if (gnt[REQ_STR]) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (abort_hit || (mem_dat_out == TERM_BYTE)) begin
               state_next = S_DONE;
            end else begin
               tx_data_next = mem_dat_out;
               state_next   = S_SEND;
            end
         end
         S_SEND: begin
            if (abort_hit) begin
               state_next = S_DONE;
            end else if (tx_ready) begin
               if (ptr_reg == ADDR_LAST) begin
                  state_next = S_DONE;
               end else begin
                  ptr_next   = ptr_reg + 8'd1;
                  state_next = S_RD;
               end
            end
         end
         S_DONE:  state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy     = (state_reg == S_RD) || (state_reg == S_WAIT) || (state_reg == S_SEND);
      done     = (state_reg == S_DONE);
      tx_valid = (state_reg == S_SEND);
      tx_data  = tx_data_reg;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         ptr_reg     <= '0;
         tx_data_reg <= '0;
      end else begin
         state_reg   <= state_next;
         ptr_reg     <= ptr_next;
         tx_data_reg <= tx_data_next;
      end
   end

endmodule

// File: tb/tb_strram_stream_ctrl.sv
// Directed and randomized bench for strram_stream_ctrl with a behavioural RAM
// and a string-walk reference model.
module tb_strram_stream_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       cpu_req, cpu_wr;
   logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
   logic       cpu_ack;
   logic       start;
   logic [7:0] start_addr;
   logic       busy, done;
   logic [7:0] tx_data;
   logic       tx_valid, tx_ready;
   logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
   logic       mem_rd, mem_wr;

   always #5 clk = ~clk;

   strram_stream_ctrl #(.TERM_BYTE(8'h00)) dut (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .start(start), .start_addr(start_addr), .busy(busy), .done(done),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .mem_addr(mem_addr), .mem_dat_in(mem_dat_in), .mem_dat_out(mem_dat_out),
      .mem_rd(mem_rd), .mem_wr(mem_wr)
   );

   // Behavioural RAM: synchronous write, read data valid the cycle after mem_rd.
   logic [7:0] ram [0:255];
   logic       ld_en;
   logic [7:0] ld_addr, ld_data;
   always @(posedge clk) begin
      if (mem_wr) ram[mem_addr] <= mem_dat_in;
      if (ld_en) ram[ld_addr] <= ld_data;
      if (mem_rd) mem_dat_out <= ram[mem_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation counters, written only here.
   logic [7:0] sent_mem [0:4095];
   int         sent_n = 0;
   int         done_cnt = 0, done_cyc = 0, last_rd_cyc = 0;
   int         both_cnt = 0, rd0_cnt = 0, stall_cnt = 0, ack_cnt = 0;
   logic [7:0] last_ack_rdata = 8'h00;
   logic [7:0] issue_kind [0:1023];
   logic       prev_v = 1'b0, prev_r = 1'b0;
   logic [7:0] prev_d = 8'h00;

   always @(negedge clk) begin
      if (mem_rd && mem_wr) both_cnt++;
      if (mem_rd) begin
         last_rd_cyc = cyc;
         if (mem_addr == 8'h00) rd0_cnt++;
      end
      issue_kind[cyc % 1024] = mem_rd ? ((mem_addr == 8'h80) ? "C" : "S") : (mem_wr ? "W" : "-");
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (cpu_ack) begin
         ack_cnt++;
         last_ack_rdata = cpu_rdata;
      end
      if (prev_v && !prev_r && tx_valid && (tx_data !== prev_d)) stall_cnt++;
      if (tx_valid && tx_ready) begin
         sent_mem[sent_n % 4096] = tx_data;
         sent_n++;
      end
      prev_v = tx_valid;
      prev_r = tx_ready;
      prev_d = tx_data;
   end

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [7:0] a, input logic [7:0] d);
      ld_addr = a;
      ld_data = d;
      ld_en   = 1'b1;
      tick();
      ld_en   = 1'b0;
   endtask

   // One CPU transaction; lat = negedges after request until ack (-1 on timeout).
   task automatic cpu_op(input logic wr, input logic [7:0] a, input logic [7:0] d,
                         output logic [7:0] rd, output int lat, output logic [17:0] snap);
      cpu_req   = 1'b1;
      cpu_wr    = wr;
      cpu_addr  = a;
      cpu_wdata = d;
      lat  = -1;
      rd   = 8'h00;
      snap = '0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (i == 0) snap = {mem_rd, mem_wr, mem_addr, mem_dat_in};
         if (cpu_ack) begin
            rd  = cpu_rdata;
            lat = i;
            break;
         end
      end
      tick();
      cpu_req = 1'b0;
   endtask

   // Reference model: walk RAM from the start address to the terminator or 8'hFF.
   logic [7:0] exp_buf [0:255];
   int         exp_n;
   task automatic build_expected(input logic [7:0] a);
      logic [7:0] p;
      p     = a;
      exp_n = 0;
      for (int k = 0; k < 256; k++) begin
         if (ram[p] == 8'h00) break;
         exp_buf[exp_n] = ram[p];
         exp_n++;
         if (p == 8'hFF) break;
         p = p + 8'd1;
      end
   endtask

   task automatic compare_sent(input string tag, input int base);
      check({tag, "_count"}, sent_n - base, exp_n);
      for (int i = 0; i < exp_n && i < sent_n - base; i++)
         check({tag, "_byte"}, {24'd0, sent_mem[(base + i) % 4096]}, {24'd0, exp_buf[i]});
   endtask

   task automatic wait_done(input string tag);
      int ok;
      ok = 0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1;
            break;
         end
      end
      check({tag, "_done_seen"}, ok, 1);
      tick();
   endtask

   task automatic run_stream(input logic [7:0] a, input string tag);
      start      = 1'b1;
      start_addr = a;
      tick();
      start      = 1'b0;
      wait_done(tag);
   endtask

   task automatic wait_valid(input string tag);
      int ok;
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx_valid) begin
            ok = 1;
            break;
         end
      end
      check({tag, "_valid_seen"}, ok, 1);
      tick();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [7:0]  rd;
   int          lat, base, t1, d0, r0, b0;
   logic [17:0] snap;
   logic [7:0]  arb_exp [0:8];
   logic [7:0]  shadow [0:255];
   logic [7:0]  ra;
   int          fin;

   initial begin
      rst = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      start = 1'b0; start_addr = 8'h00; tx_ready = 1'b1;
      ld_en = 1'b0; ld_addr = 8'h00; ld_data = 8'h00;
      tick();
      tick();
      check("reset_ctrl", {busy, done, tx_valid, cpu_ack, mem_rd, mem_wr}, 6'b0);
      check("reset_tx_data", tx_data, 8'h00);
      check("reset_cpu_rdata", cpu_rdata, 8'h00);
      check("reset_mem_bus", {mem_addr, mem_dat_in}, 16'h0000);
      rst = 1'b0;

      load(8'h0A, 8'h41); load(8'h0B, 8'h42); load(8'h0C, 8'h00);
      load(8'hFE, 8'h31); load(8'hFF, 8'h32); load(8'h00, 8'h99);
      load(8'h40, 8'h58); load(8'h41, 8'h59); load(8'h42, 8'h5A); load(8'h43, 8'h00);
      load(8'h50, 8'h61); load(8'h51, 8'h62); load(8'h52, 8'h63); load(8'h53, 8'h00);
      load(8'h80, 8'h77);

      // CPU write then read back.
      cpu_op(1'b1, 8'h20, 8'h55, rd, lat, snap);
      check("cpu_wr_latency", lat, 1);
      check("cpu_wr_issue", snap, {1'b0, 1'b1, 8'h20, 8'h55});
      cpu_op(1'b0, 8'h20, 8'h00, rd, lat, snap);
      check("cpu_rd_latency", lat, 1);
      check("cpu_rd_issue", snap[17:8], {1'b1, 1'b0, 8'h20});
      check("cpu_rd_data", rd, 8'h55);
      tick();
      check("cpu_rdata_hold", cpu_rdata, 8'h55);
      check("cpu_ack_single", cpu_ack, 1'b0);

      // "AB\0" at 10.
      base = sent_n;
      d0 = done_cnt;
      run_stream(8'h0A, "str_ab");
      build_expected(8'h0A);
      compare_sent("str_ab", base);
      check("str_ab_first", sent_mem[base % 4096], 8'h41);
      check("str_ab_done_timing", done_cyc, last_rd_cyc + 2);
      check("str_ab_done_count", done_cnt - d0, 1);

      // Top-of-memory stop without wrapping.
      base = sent_n;
      r0 = rd0_cnt;
      run_stream(8'hFE, "str_fe");
      build_expected(8'hFE);
      compare_sent("str_fe", base);
      check("str_fe_no_wrap_read", rd0_cnt - r0, 0);

      // Sink stalls for several cycles while the CPU writes.
      base = sent_n;
      r0 = stall_cnt;
      tx_ready   = 1'b0;
      start      = 1'b1;
      start_addr = 8'h40;
      tick();
      start = 1'b0;
      wait_valid("stall");
      cpu_op(1'b1, 8'h90, 8'hA5, rd, lat, snap);
      check("stall_cpu_wr_latency", lat, 1);
      tick(); tick(); tick();
      check("stall_tx_valid", tx_valid, 1'b1);
      check("stall_tx_data", tx_data, 8'h58);
      check("stall_data_stable", stall_cnt - r0, 0);
      tx_ready = 1'b1;
      wait_done("stall");
      build_expected(8'h40);
      compare_sent("stall", base);
      cpu_op(1'b0, 8'h90, 8'h00, rd, lat, snap);
      check("stall_cpu_readback", rd, 8'hA5);

      // Conflicts: CPU reads continuously while the stream walks "abc".
      arb_exp[0] = "C"; arb_exp[1] = "S"; arb_exp[2] = "C"; arb_exp[3] = "-"; arb_exp[4] = "S";
      arb_exp[5] = "C"; arb_exp[6] = "-"; arb_exp[7] = "C"; arb_exp[8] = "S";
      base = sent_n;
      b0 = both_cnt;
      start      = 1'b1;
      start_addr = 8'h50;
      tick();
      start     = 1'b0;
      cpu_req   = 1'b1;
      cpu_wr    = 1'b0;
      cpu_addr  = 8'h80;
      t1        = cyc;
      wait_done("arb");
      cpu_req = 1'b0;
      tick();
      tick();
      for (int k = 0; k < 9; k++)
         check("arb_issue_order", issue_kind[(t1 + k) % 1024], arb_exp[k]);
      build_expected(8'h50);
      compare_sent("arb", base);
      check("arb_no_dual_strobe", both_cnt - b0, 0);
      check("arb_cpu_rdata", last_ack_rdata, 8'h77);

      // Reset while holding a byte in S_SEND.
      tx_ready   = 1'b0;
      start      = 1'b1;
      start_addr = 8'h40;
      tick();
      start = 1'b0;
      wait_valid("rst_send");
      d0  = done_cnt;
      r0  = ack_cnt;
      rst = 1'b1;
      tick();
      check("rst_send_ctrl", {busy, done, tx_valid, cpu_ack, mem_rd, mem_wr}, 6'b0);
      check("rst_send_tx_data", tx_data, 8'h00);
      check("rst_send_cpu_rdata", cpu_rdata, 8'h00);
      rst      = 1'b0;
      tx_ready = 1'b1;
      check("rst_send_no_done", done_cnt - d0, 0);
      base = sent_n;
      run_stream(8'h0A, "post_rst");
      build_expected(8'h0A);
      compare_sent("post_rst", base);

      // Randomized streams with random sink backpressure and CPU traffic.
      for (int a = 0; a < 8'hBF; a++)
         load(a[7:0], ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255)));
      load(8'hBF, 8'h00);
      for (int a = 8'hE0; a < 8'hF0; a++) begin
         shadow[a] = 8'(a ^ 8'h3C);
         load(a[7:0], shadow[a]);
      end
      for (int it = 0; it < 6; it++) begin
         ra = 8'($urandom_range(0, 8'hB8));
         build_expected(ra);
         base = sent_n;
         fin  = 0;
         fork
            begin
               run_stream(ra, "rand_stream");
               fin = 1;
            end
            begin
               while (fin == 0) begin
                  tx_ready = ($urandom_range(0, 3) != 0);
                  tick();
               end
               tx_ready = 1'b1;
            end
            begin
               logic [7:0]  ca, cd, crd;
               logic        cw;
               int          clat;
               logic [17:0] csnap;
               while (fin == 0) begin
                  cw = $urandom_range(0, 1) == 1;
                  ca = 8'($urandom_range(8'hE0, 8'hEF));
                  cd = 8'($urandom);
                  cpu_op(cw, ca, cd, crd, clat, csnap);
                  check("rand_cpu_latency", (clat >= 1 && clat <= 2), 1);
                  if (cw) shadow[ca] = cd;
                  else check("rand_cpu_rdata", crd, shadow[ca]);
                  repeat ($urandom_range(0, 2)) tick();
               end
            end
         join
         compare_sent("rand_stream", base);
      end

      check("global_no_dual_strobe", both_cnt, 0);
      check("global_tx_stable", stall_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/strram_stream_ctrl.md
STRRAM_STREAM_CTRL -- requirements
Module: strram_stream_ctrl

Interface
REQ-001 SHALL have parameter TERM_BYTE, default 8'h00, meaning the string terminator value.
REQ-002 SHALL have these ports, one per line: name, direction, width, meaning.
  clk  in  1  the single clock; all logic on rising edge.
  rst  in  1  reset, synchronous, active-high.
  cpu_req  in  1  CPU access request, held high until cpu_ack.
  cpu_wr  in  1  1 = write, 0 = read; stable while cpu_req is high.
  cpu_addr  in  8  CPU RAM address.
  cpu_wdata  in  8  CPU write data.
  cpu_rdata  out  8  CPU read data, valid with cpu_ack.
  cpu_ack  out  1  one-cycle completion pulse.
  start  in  1  stream start pulse.
  start_addr  in  8  first string address, sampled with start.
  busy  out  1  stream in progress.
  done  out  1  one-cycle stream-finished pulse.
  tx_data  out  8  streamed byte.
  tx_valid  out  1  tx_data valid.
  tx_ready  in  1  sink accepts byte.
  mem_addr  out  8  RAM address.
  mem_dat_in  out  8  RAM write data.
  mem_dat_out  in  8  RAM read data, valid 1 cycle after the mem_rd cycle.
  mem_rd  out  1  RAM read strobe.
  mem_wr  out  1  RAM write strobe.

Function
REQ-003 SHALL drive the RAM port for at most one transaction per cycle; mem_rd and mem_wr SHALL never both be high.
REQ-004 SHALL raise a CPU issue request when cpu_req=1, no CPU transaction is outstanding, and cpu_ack=0 in the current cycle.
REQ-005 SHALL raise a stream issue request only in state S_RD.
REQ-006 SHALL grant a lone requester immediately; on a conflict it SHALL grant the requester that lost the previous conflict; after reset the CPU SHALL win the first conflict.
REQ-007 SHALL handle a granted CPU write as follows: mem_wr=1, mem_addr=cpu_addr, mem_dat_in=cpu_wdata in the issue cycle; cpu_ack=1 in the next cycle.
REQ-008 SHALL handle a granted CPU read as follows: mem_rd=1 in the issue cycle; cpu_ack=1 and cpu_rdata=mem_dat_out in the next cycle; cpu_rdata SHALL hold between reads.
REQ-009 SHALL implement stream FSM states IDLE, S_RD, S_WAIT, S_SEND, S_DONE.
REQ-010 SHALL handle IDLE: on start=1, load the pointer from start_addr, set busy=1, and go to S_RD.
REQ-011 SHALL ignore start in any state other than IDLE.
REQ-012 SHALL handle S_RD: wait for a grant; when granted, issue mem_rd at the pointer and go to S_WAIT.
REQ-013 SHALL handle S_WAIT by capturing mem_dat_out. If it equals TERM_BYTE, the byte SHALL NOT be sent and the FSM SHALL go to S_DONE. Otherwise tx_data SHALL be latched, tx_valid=1, and the FSM SHALL go to S_SEND.
REQ-014 SHALL handle S_SEND: hold tx_data and tx_valid until tx_ready=1. On acceptance, if the pointer is 8'hFF the FSM SHALL go to S_DONE (no wrap to 8'h00); otherwise the pointer SHALL increment and the FSM SHALL go to S_RD.
REQ-015 SHALL handle S_DONE: done=1 and busy=0 for one cycle, then IDLE.
REQ-016 SHALL allow CPU transactions during IDLE, S_WAIT, S_SEND and S_DONE without stream stall.
REQ-017 SHALL allow a CPU read in flight and a stream capture to complete in the same cycle when their issue cycles differ.
REQ-018 SHALL limit the stream's worst-case delay per byte from CPU contention to 1 cycle.

Reset
REQ-019 SHALL on rst=1 set the FSM to IDLE, pointer=0, busy=0, done=0, tx_valid=0, tx_data=0, cpu_ack=0, cpu_rdata=0, mem_rd=0, mem_wr=0, mem_addr=0, mem_dat_in=0, conflict-priority=CPU.
REQ-020 SHALL abort any transaction or stream in progress on rst asserted mid-operation, without emitting cpu_ack or done.

Configuration
REQ-021 SHALL add, when STRRAM_STREAM_ABORT_EN is defined, input port abort (1 bit). abort=1 in S_RD, S_WAIT or S_SEND SHALL drop tx_valid, cancel the byte in progress and go to S_DONE; a byte accepted in the same cycle counts as sent.
REQ-022 SHALL have, when STRRAM_STREAM_ABORT_EN is undefined, no abort port, and streams SHALL end only via TERM_BYTE or address 8'hFF.

Structure
REQ-023 SHALL take the FSM state encoding, the default TERM_BYTE and the address width of 8 from shared package strram_pkg.
REQ-024 SHALL place the two-way round-robin conflict arbiter in sub-module strram_rr_arb (inputs: two requests; outputs: two one-hot grants; priority register inside).

Verification
REQ-025 SHALL cover these directed scenarios:
  RAM[10..12]="AB\0", start_addr=10, tx_ready=1 -> tx bytes 8'h41, 8'h42; done one cycle after the terminator is captured; 8'h00 never sent.
  CPU write 0x55 to 0x20, then CPU read 0x20 -> cpu_ack one cycle after each issue; cpu_rdata=0x55.
  Stream in S_RD and CPU read asserted the same cycle, repeated over 3 bytes -> grants alternate CPU, stream, CPU; no RAM cycle has both strobes.
  RAM[0xFE]=0x31, RAM[0xFF]=0x32, start_addr=0xFE -> 0x31, 0x32 sent; done; no read of address 0x00.
  tx_ready low for 5 cycles in S_SEND while the CPU writes -> tx_data stable, CPU write acked, stream resumes.
  rst in S_SEND -> all outputs at reset values next cycle; a start after rst streams normally.
